// File: rtl/reg_file_dump.sv
// reg_file_dump
//   Read-side sequencer for the 16-entry register file (R0-R14 plus the
//   externally supplied R15). A start request latches an inclusive index
//   range. The block then fetches two registers per fetch through both
//   register-file read selects and streams them out one word per beat.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   start, abort      dump request (taken only in IDLE) / cancel an active dump
//   first_reg         first index of the range (inclusive), latched on start
//   last_reg          last index of the range (inclusive), latched on start
//   Source_select_0/1 register-file read selects (ptr, ptr+1 mod 16)
//   rf_out_0/1        register-file read data, combinational from the selects
//   dump_valid/ready  beat handshake
//   dump_data/index   the beat's register value and its index
//   dump_last         marks the final beat of the range
//   busy              high in every state except IDLE
//   done              one-cycle pulse after the final beat is accepted
//
// Handshake: a beat transfers on a rising edge where dump_valid && dump_ready.
// While dump_valid is high and dump_ready is low, dump_data, dump_index and
// dump_last stay stable. dump_valid only drops after a transfer, or on abort
// or reset. dump_valid, dump_last and done decode only the registered state,
// so there is no combinational path from dump_ready to them.

module reg_file_dump #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       first_reg,
  input  logic [3:0]       last_reg,
  output logic [3:0]       Source_select_0,
  output logic [3:0]       Source_select_1,
  input  logic [WIDTH-1:0] rf_out_0,
  input  logic [WIDTH-1:0] rf_out_1,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] dump_data,
  output logic [3:0]       dump_index,
  output logic             dump_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND0 = 3'd2,
    S_SEND1 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [3:0]       ptr, ptr_next;
  // 5 bits, because a full wrap-around range holds 16 words
  logic [4:0]       remaining, remaining_next;
  logic [WIDTH-1:0] buf0, buf1;

  assign Source_select_0 = ptr;
  assign Source_select_1 = ptr + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 4'd0;
      remaining <= 5'd0;
      buf0      <= '0;
      buf1      <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      remaining <= remaining_next;
      // Snapshot the pair. Register writes made after this cycle are not seen.
      if (state == S_FETCH) begin
        buf0 <= rf_out_0;
        buf1 <= rf_out_1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    remaining_next = remaining;
    dump_valid     = 1'b0;
    dump_data      = '0;
    dump_index     = 4'd0;
    dump_last      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        // If abort arrives together with start, the block stays idle.
        if (start && !abort) begin
          ptr_next       = first_reg;
          // The 4-bit difference wraps mod 16, which handles last < first.
          remaining_next = {1'b0, last_reg - first_reg} + 5'd1;
          state_next     = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_SEND0;
      end
      S_SEND0: begin
        dump_valid = 1'b1;
        dump_data  = buf0;
        dump_index = ptr;
        dump_last  = (remaining == 5'd1);
        if (dump_ready) begin
          state_next = (remaining == 5'd1) ? S_DONE : S_SEND1;
        end
      end
      S_SEND1: begin
        dump_valid = 1'b1;
        dump_data  = buf1;
        dump_index = ptr + 4'd1;
        dump_last  = (remaining == 5'd2);
        if (dump_ready) begin
          ptr_next       = ptr + 4'd2;
          remaining_next = remaining - 5'd2;
          state_next     = (remaining == 5'd2) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a beat that transfers this cycle.
    if (abort && (state != S_IDLE)) begin
      state_next     = S_IDLE;
      remaining_next = 5'd0;
    end
  end

endmodule

// File: tb/tb_reg_file_dump.sv
// tb_reg_file_dump
//   Directed bench for reg_file_dump. A reference model turns each accepted
//   start into the list of beats the range must produce. A compare process
//   checks every cycle against that list for beats, done and busy. Literal
//   expectations pin the beat counts, the final values and the done timing.

module tb_reg_file_dump;

  localparam int WIDTH = 32;
  localparam int QW    = WIDTH + 5;   // {last, index[3:0], data}

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       first_reg = 4'd0;
  logic [3:0]       last_reg = 4'd0;
  logic [3:0]       Source_select_0, Source_select_1;
  logic [WIDTH-1:0] rf_out_0, rf_out_1;
  logic             dump_valid;
  logic             dump_ready = 1'b1;
  logic [WIDTH-1:0] dump_data;
  logic [3:0]       dump_index;
  logic             dump_last;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] rf_mem [16];

  assign rf_out_0 = rf_mem[Source_select_0];
  assign rf_out_1 = rf_mem[Source_select_1];

  reg_file_dump #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .Source_select_0(Source_select_0), .Source_select_1(Source_select_1),
    .rf_out_0(rf_out_0), .rf_out_1(rf_out_1),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_index(dump_index), .dump_last(dump_last),
    .busy(busy), .done(done)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [QW-1:0] exp_q[$];
  logic          model_busy = 1'b0;
  logic          expect_done = 1'b0;
  logic          prev_stall = 1'b0;
  int            hs_count = 0;
  int            done_cnt = 0;
  int            start_cyc = 0;
  int            done_cyc = 0;
  logic [3:0]    last_idx = 4'd0;
  logic [WIDTH-1:0] last_data = '0;

  // Build the beat list for an inclusive, possibly wrapping range.
  task automatic model_start(input logic [3:0] f, input logic [3:0] l);
    int n;
    logic [3:0] idx;
    n = ((int'(l) - int'(f) + 16) % 16) + 1;
    for (int i = 0; i < n; i++) begin
      idx = 4'((int'(f) + i) % 16);
      exp_q.push_back({(i == n - 1), idx, rf_mem[idx]});
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [QW-1:0] front;
    logic          nd;
    if (reset) begin
      exp_q.delete();
      model_busy  = 1'b0;
      expect_done = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      chk("busy", {63'd0, busy}, {63'd0, model_busy});
      chk("done", {63'd0, done}, {63'd0, expect_done});
      chk("sel1", {60'd0, Source_select_1}, {60'd0, 4'(Source_select_0 + 4'd1)});
      if (expect_done) chk("valid_in_done", {63'd0, dump_valid}, 64'd0);
      if (prev_stall) chk("valid_held", {63'd0, dump_valid}, 64'd1);
      if (dump_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {63'd0, dump_valid}, 64'd0);
        end else begin
          front = exp_q[0];
          chk("index", {60'd0, dump_index}, {60'd0, front[WIDTH+3:WIDTH]});
          chk("data", {32'd0, dump_data}, {32'd0, front[WIDTH-1:0]});
          chk("last", {63'd0, dump_last}, {63'd0, front[QW-1]});
        end
      end

      nd = 1'b0;
      if (dump_valid && dump_ready && exp_q.size() != 0) begin
        front = exp_q.pop_front();
        hs_count++;
        last_idx  = front[WIDTH+3:WIDTH];
        last_data = front[WIDTH-1:0];
        if (front[QW-1] && !abort) nd = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start && !abort && !model_busy) begin
        model_start(first_reg, last_reg);
        model_busy = 1'b1;
        start_cyc  = cyc;
      end else if (abort && model_busy) begin
        exp_q.delete();
        model_busy = 1'b0;
        nd = 1'b0;
      end else if (expect_done) begin
        model_busy = 1'b0;
      end
      prev_stall  = dump_valid && !dump_ready && !abort;
      expect_done = nd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [3:0] f, input logic [3:0] l);
    @(posedge clk); #1;
    start = 1'b1; first_reg = f; last_reg = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  // Returns after the posedge at which dump_valid is shown with the given index.
  task automatic wait_beat(input logic [3:0] idx);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (dump_valid && dump_index == idx) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("beat_timeout", {60'd0, idx}, 64'hF00);
  endtask

  // ---------------- stimulus ----------------
  int hs0, dn0;

  initial begin
    for (int i = 0; i < 15; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[15] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, dump_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sel0", {60'd0, Source_select_0}, 64'd0);
    chk("rst_sel1", {60'd0, Source_select_1}, 64'd1);
    chk("rst_data", {32'd0, dump_data}, 64'd0);
    chk("rst_index", {60'd0, dump_index}, 64'd0);
    chk("rst_last", {63'd0, dump_last}, 64'd0);

    // T1: full range with ready held high
    hs0 = hs_count; dn0 = done_cnt;
    do_start(4'd0, 4'd15);
    wait_idle();
    chk("t1_beats", 64'(hs_count - hs0), 64'd16);
    chk("t1_last_idx", {60'd0, last_idx}, 64'd15);
    chk("t1_last_data", {32'd0, last_data}, 64'hDEADBEEF);
    chk("t1_done_cycle", 64'(done_cyc - start_cyc), 64'd25);
    chk("t1_done_cnt", 64'(done_cnt - dn0), 64'd1);

    // T2: odd-length range, the final beat comes from SEND0
    hs0 = hs_count;
    do_start(4'd3, 4'd5);
    wait_idle();
    chk("t2_beats", 64'(hs_count - hs0), 64'd3);
    chk("t2_last_idx", {60'd0, last_idx}, 64'd5);
    chk("t2_last_data", {32'd0, last_data}, 64'h1005);

    // T3: wrapping range 14..1
    hs0 = hs_count;
    do_start(4'd14, 4'd1);
    wait_idle();
    chk("t3_beats", 64'(hs_count - hs0), 64'd4);
    chk("t3_last_idx", {60'd0, last_idx}, 64'd1);
    chk("t3_last_data", {32'd0, last_data}, 64'h1001);

    // start together with abort in IDLE leaves the block idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; first_reg = 4'd0; last_reg = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", {63'd0, busy}, 64'd0);

    // T4: ready dropped for 5 cycles while index 3 (SEND1) is offered
    hs0 = hs_count;
    do_start(4'd0, 4'd15);
    wait_beat(4'd3);
    dump_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 dump_ready = 1'b1;
    wait_idle();
    chk("t4_beats", 64'(hs_count - hs0), 64'd16);
    chk("t4_done_cycle", 64'(done_cyc - start_cyc), 64'd30);

    // T5: abort together with the handshake on index 6
    hs0 = hs_count; dn0 = done_cnt;
    do_start(4'd0, 4'd15);
    wait_beat(4'd6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_idle_next", {63'd0, busy}, 64'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("t5_beats", 64'(hs_count - hs0), 64'd7);
    chk("t5_last_idx", {60'd0, last_idx}, 64'd6);
    chk("t5_no_done", 64'(done_cnt - dn0), 64'd0);
    hs0 = hs_count;
    do_start(4'd8, 4'd8);
    wait_idle();
    chk("t5_single_beats", 64'(hs_count - hs0), 64'd1);
    chk("t5_single_data", {32'd0, last_data}, 64'h1008);

    // T6: start while busy is ignored; then reset while index 4 (SEND0) is offered
    dn0 = done_cnt;
    do_start(4'd0, 4'd15);
    @(posedge clk); #1;
    do_start(4'd3, 4'd5);
    wait_beat(4'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_valid", {63'd0, dump_valid}, 64'd0);
    chk("t6_done", {63'd0, done}, 64'd0);
    chk("t6_sel0", {60'd0, Source_select_0}, 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt - dn0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
